// File: rtl/ps2_keycode_decoder.sv
// PS/2 keyboard front end: synchronises and filters the raw PS/2 lines,
// deserialises 11-bit frames, and turns scan-code set 2 byte streams
// (with E0 extended and F0 break prefixes) into a 9-bit keyCode with
// one-clock make / brakee strobes. frameErr pulses on any malformed frame.
module ps2_keycode_decoder #(
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       kbdClk,
    input  logic       kbdDat,
    output logic [8:0] keyCode,
    output logic       make,
    output logic       brakee,
    output logic       frameErr
);

    localparam int unsigned FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } bit_state_t;

    // Synchroniser stages; reset high so an idle bus is seen after reset.
    logic [1:0] clk_sync;
    logic [1:0] dat_sync;
    logic       clk_s;
    logic       dat_s;

    // Glitch filter
    logic          filt_clk;
    logic [FW-1:0] filt_cnt;
    logic          sample_stb;

    // Bit-level frame receiver
    bit_state_t    state;
    bit_state_t    state_next;
    logic [7:0]    shift;
    logic [2:0]    bit_cnt;
    logic          par_bit;
    logic [TW-1:0] tcnt;
    logic          timeout;
    logic          err_next;
    logic          valid_next;
    logic          flag_clr;
    logic          byte_valid;

    // Prefix flags
    logic ext;
    logic brk;

    assign clk_s = clk_sync[1];
    assign dat_s = dat_sync[1];

    // Two-flop synchronisers for both asynchronous PS/2 lines.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            clk_sync <= '1;
            dat_sync <= '1;
        end else begin
            clk_sync <= {clk_sync[0], kbdClk};
            dat_sync <= {dat_sync[0], kbdDat};
        end
    end

    // Filtered clock follows the synchronised clock only after FILTER_LEN
    // consecutive differing samples; a filtered falling edge yields the strobe.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            filt_clk   <= 1'b1;
            filt_cnt   <= '0;
            sample_stb <= 1'b0;
        end else begin
            sample_stb <= 1'b0;
            if (clk_s != filt_clk) begin
                if (filt_cnt == FILT_LAST) begin
                    filt_clk   <= clk_s;
                    filt_cnt   <= '0;
                    sample_stb <= filt_clk;
                end else begin
                    filt_cnt <= filt_cnt + 1'b1;
                end
            end else begin
                filt_cnt <= '0;
            end
        end
    end

    // Frame receiver state register.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Frame receiver next state, error / byte-valid decisions and timeout.
    always_comb begin
        state_next = state;
        err_next   = 1'b0;
        valid_next = 1'b0;
        timeout    = 1'b0;
        flag_clr   = 1'b0;
        if (sample_stb) begin
            case (state)
                IDLE: begin
                    if (!dat_s) begin
                        state_next = DATA;
                    end else begin
                        err_next = 1'b1;
                    end
                end
                DATA: begin
                    if (bit_cnt == 3'd7) begin
                        state_next = PARITY;
                    end
                end
                PARITY: begin
                    state_next = STOP;
                end
                STOP: begin
                    state_next = IDLE;
                    if (dat_s && (^{shift, par_bit})) begin
                        valid_next = 1'b1;
                    end else begin
                        err_next = 1'b1;
                        flag_clr = 1'b1;
                    end
                end
                default: state_next = IDLE;
            endcase
        end else if ((state != IDLE) && (tcnt == TO_LAST)) begin
            state_next = IDLE;
            err_next   = 1'b1;
            timeout    = 1'b1;
            flag_clr   = 1'b1;
        end
    end

    // Receiver datapath. tcnt holds the number of cycles elapsed since the
    // last strobe (1 in the cycle after it), so the timeout pulse lands
    // exactly TIMEOUT_CYCLES cycles after that strobe.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            shift      <= '0;
            bit_cnt    <= '0;
            par_bit    <= 1'b0;
            tcnt       <= '0;
            byte_valid <= 1'b0;
            frameErr   <= 1'b0;
        end else begin
            byte_valid <= valid_next;
            frameErr   <= err_next;
            if (sample_stb) begin
                case (state)
                    IDLE:    bit_cnt <= '0;
                    DATA: begin
                        shift   <= {dat_s, shift[7:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                    PARITY:  par_bit <= dat_s;
                    default: ;
                endcase
            end
            if (sample_stb) begin
                tcnt <= TW'(1);
            end else if ((state == IDLE) || timeout) begin
                tcnt <= '0;
            end else begin
                tcnt <= tcnt + 1'b1;
            end
        end
    end

    // Prefix handling and key event outputs, one cycle after byte_valid.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            ext     <= 1'b0;
            brk     <= 1'b0;
            keyCode <= '0;
            make    <= 1'b0;
            brakee  <= 1'b0;
        end else begin
            make   <= 1'b0;
            brakee <= 1'b0;
            if (flag_clr) begin
                ext <= 1'b0;
                brk <= 1'b0;
            end else if (byte_valid) begin
                case (shift)
                    8'hE0: ext <= 1'b1;
                    8'hF0: brk <= 1'b1;
                    8'h00, 8'hAA, 8'hFA, 8'hEE, 8'hFC, 8'hFF: begin
                        ext <= 1'b0;
                        brk <= 1'b0;
                    end
                    default: begin
                        keyCode <= {ext, shift};
                        make    <= ~brk;
                        brakee  <= brk;
                        ext     <= 1'b0;
                        brk     <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
